// File: rtl/unsigned_shift_add_multiplier.sv
// Sequential unsigned multiply-accumulate: {product_hi, product_lo} = multiplicand * multiplier + addend,
// one multiplier bit per cycle, with a go/done handshake shared with the restoring divider.
module unsigned_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] addend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_WAIT, ST_COMPUTE, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh_hi;
  logic [WIDTH-1:0] sh_lo;
  logic [CW-1:0]    cnt_dec;

  // One add-and-shift step; the carry out of the add lands in the top bit of the shifted pair.
  always_comb begin
    sum     = p_lo_q[0] ? (p_hi_q + {1'b0, m_q}) : p_hi_q;
    sh_hi   = {1'b0, sum[WIDTH:1]};
    sh_lo   = {sum[0], p_lo_q[WIDTH-1:1]};
    cnt_dec = cnt_q - CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    case (state_q)
      ST_WAIT: begin
        if (go) begin
          // Addend sits in the upper half so WIDTH right shifts bring it down to weight 1.
          p_hi_d  = {1'b0, addend};
          p_lo_d  = multiplier;
          m_d     = multiplicand;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        p_hi_d = sh_hi;
        p_lo_d = sh_lo;
        cnt_d  = cnt_dec;
        if (cnt_dec == '0) begin
          prod_hi_d = sh_hi[WIDTH-1:0];
          prod_lo_d = sh_lo;
          ovf_d     = |sh_hi[WIDTH-1:0];
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_unsigned_shift_add_multiplier.sv
// Scoreboard bench for unsigned_shift_add_multiplier: an 8-bit instance for function/protocol
// and a 32-bit instance fed with quotient/divisor/remainder triples for the divider round trip.
module tb_unsigned_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] prod;
    logic        ovf;
    int          t;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];

  // 8-bit instance
  logic       go8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, c8 = '0;
  logic       busy8, done8, ovf8;
  logic [7:0] hi8, lo8;

  unsigned_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8),
    .multiplicand(a8), .multiplier(b8), .addend(c8),
    .busy(busy8), .done(done8),
    .product_hi(hi8), .product_lo(lo8), .overflow(ovf8)
  );

  // 32-bit instance
  logic        go32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, c32 = '0;
  logic        busy32, done32, ovf32;
  logic [31:0] hi32, lo32;

  unsigned_shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .go(go32),
    .multiplicand(a32), .multiplier(b32), .addend(c32),
    .busy(busy32), .done(done32),
    .product_hi(hi32), .product_lo(lo32), .overflow(ovf32)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check_eq("spurious_done8", 64'(done8), 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check_eq("prod8", {48'h0, hi8, lo8}, e.prod);
        check_eq("ovf8", 64'(ovf8), 64'(e.ovf));
        check_eq("lat8", 64'(cyc - e.t), 64'd8);
      end
    end
  end

  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        check_eq("spurious_done32", 64'(done32), 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check_eq("prod32", {hi32, lo32}, e.prod);
        check_eq("ovf32", 64'(ovf32), 64'(e.ovf));
        check_eq("lat32", 64'(cyc - e.t), 64'd32);
      end
    end
  end

  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    logic [15:0] p;
    p = {8'h0, a} * {8'h0, b} + {8'h0, c};
    e.prod = {48'h0, p};
    e.ovf  = (p[15:8] != 8'h0);
    e.t    = cyc + 1;
    q8.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int k = 0;
    @(negedge clk);
    while (busy8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check_eq("timeout_idle8", 64'(busy8), 64'd0);
    a8 = a; b8 = b; c8 = c; go8 = 1'b1;
    push8(a, b, c);
    @(posedge clk);
    #1 go8 = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] dividend);
    int k = 0;
    exp_t e;
    @(negedge clk);
    while (busy32 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check_eq("timeout_idle32", 64'(busy32), 64'd0);
    a32 = a; b32 = b; c32 = c; go32 = 1'b1;
    e.prod = {32'h0, dividend};
    e.ovf  = 1'b0;
    e.t    = cyc + 1;
    q32.push_back(e);
    @(posedge clk);
    #1 go32 = 1'b0;
  endtask

  task automatic wait_idle8();
    int k = 0;
    while ((q8.size() != 0 || busy8) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_eq("timeout_done8", 64'(q8.size()), 64'd0);
  endtask

  task automatic wait_idle32();
    int k = 0;
    while ((q32.size() != 0 || busy32) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_eq("timeout_done32", 64'(q32.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dvd, dvs;
    int k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy8", 64'(busy8), 64'd0);
    check_eq("rst_done8", 64'(done8), 64'd0);
    check_eq("rst_prod8", {48'h0, hi8, lo8}, 64'd0);
    check_eq("rst_ovf8", 64'(ovf8), 64'd0);
    check_eq("rst_busy32", 64'(busy32), 64'd0);
    check_eq("rst_prod32", {hi32, lo32}, 64'd0);
    rst = 1'b0;

    // Basic, maximum, zero operands
    drive8(8'd13, 8'd11, 8'd7);
    wait_idle8();
    check_eq("basic_prod", {48'h0, hi8, lo8}, 64'h0096);
    drive8(8'd255, 8'd255, 8'd255);
    wait_idle8();
    repeat (5) @(negedge clk);
    check_eq("hold_prod", {48'h0, hi8, lo8}, 64'hFF00);
    check_eq("hold_ovf", 64'(ovf8), 64'd1);
    drive8(8'd0, 8'd200, 8'd0);
    drive8(8'd200, 8'd0, 8'd9);
    wait_idle8();
    check_eq("zero_prod", {48'h0, hi8, lo8}, 64'd9);

    // go pulses during COMPUTE and DONE must be ignored
    drive8(8'd100, 8'd3, 8'd4);
    repeat (3) @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; c8 = 8'd1; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    k = 0;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 64'(done8), 64'd1);
    a8 = 8'd2; b8 = 8'd2; c8 = 8'd2; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    check_eq("go_in_done_ignored", 64'(busy8), 64'd0);
    check_eq("ignored_prod", {48'h0, hi8, lo8}, 64'h0130);
    repeat (15) @(negedge clk);
    check_eq("ignored_busy_later", 64'(busy8), 64'd0);

    // go held high: accepts every 10 cycles
    @(negedge clk);
    a8 = 8'd17; b8 = 8'd19; c8 = 8'd5; go8 = 1'b1;
    push8(8'd17, 8'd19, 8'd5);
    for (int i = 0; i < 2; i++) begin
      repeat (10) @(negedge clk);
      push8(8'd17, 8'd19, 8'd5);
    end
    @(posedge clk);
    #1 go8 = 1'b0;
    wait_idle8();
    check_eq("held_prod", {48'h0, hi8, lo8}, 64'd328);

    // Reset four cycles into COMPUTE aborts without a done
    drive8(8'd50, 8'd60, 8'd70);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    q8.delete();
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy", 64'(busy8), 64'd0);
    check_eq("abort_done", 64'(done8), 64'd0);
    check_eq("abort_prod", {48'h0, hi8, lo8}, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_idle", 64'(busy8), 64'd0);
    drive8(8'd7, 8'd9, 8'd3);
    wait_idle8();
    check_eq("after_abort_prod", {48'h0, hi8, lo8}, 64'd66);

    for (int i = 0; i < 8; i++) begin
      drive8(8'($urandom), 8'($urandom), 8'($urandom));
    end
    wait_idle8();

    // Divider round trip at 32 bits
    for (int i = 0; i < 1000; i++) begin
      dvd = $urandom;
      dvs = (i % 2 == 1) ? 32'($urandom_range(65535, 1)) : $urandom;
      if (dvs == 32'h0) dvs = 32'h1;
      drive32(dvd / dvs, dvs, dvd % dvs, dvd);
    end
    drive32(32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF);
    wait_idle32();
    check_eq("rt_last_lo", {32'h0, lo32}, 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
